// File: rtl/red_alu_seq_pkg.sv
// Shared types and ALU select encodings for the reduction-ALU sequencer.
package red_alu_seq_pkg;

  // Job phases; IDLE is the all-zero encoding so a cleared state register is idle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_MAC    = 3'd2,
    S_DRAIN  = 3'd3,
    S_FOLD   = 3'd4,
    S_REDUCE = 3'd5,
    S_FLUSH  = 3'd6
  } state_t;

  // Multiplier input 1 select
  localparam logic [1:0] M1_DATA   = 2'd0;
  localparam logic [1:0] M1_ACCHI  = 2'd1;
  localparam logic [1:0] M1_ACCMID = 2'd2;

  // Adder input 2 select
  localparam logic [1:0] M2_ACC   = 2'd0;
  localparam logic [1:0] M2_ACCLO = 2'd1;
  localparam logic [1:0] M2_ZERO  = 2'd2;
  localparam logic [1:0] M2_ROM   = 2'd3;

  // Adder input 3 select
  localparam logic M3_MUL  = 1'b0;
  localparam logic M3_BRED = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/red_alu_wb_pipe.sv
// Fixed-depth token delay line: a token entering now leaves DEPTH cycles later.
module red_alu_wb_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH:0]   vld_shift;
  logic [W-1:0]     dat [DEPTH];

  assign vld_shift = {vld, in_valid};

  // Shift tokens one stage per cycle; reset drops every token in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld    <= vld_shift[DEPTH-1:0];
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/red_alu_seq.sv
// Job sequencer for the 4-core reduction ALU: clear, MAC stream, carry fold,
// per-core Barrett reduction and result strobes.
module red_alu_seq
  import red_alu_seq_pkg::*;
#(
  parameter int NMAX      = 16,
  parameter int MUL_LAT   = 3,
  parameter int BRED_LAT  = 6,
  parameter int FOLD_ADDR = 2*NMAX
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NMAX+1)-1:0]    num_words,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NMAX)-1:0]      data_rd_addr,
  output logic [$clog2(2*NMAX+1)-1:0]  rom_addr,
  output logic                         rst_acc,
  output logic                         only_multiply,
  output logic                         m0sel,
  output logic                         m3sel,
  output logic                         addsub,
  output logic [1:0]                   m1sel,
  output logic [1:0]                   m2sel,
  output logic [1:0]                   barrett_input_sel,
  output logic                         wen_acc_core1,
  output logic                         wen_acc_core2,
  output logic                         wen_acc_core3,
  output logic                         wen_acc_core4,
  output logic                         out_valid,
  output logic [1:0]                   out_idx
);

  localparam int NW_W    = $clog2(NMAX+1);
  localparam int AD_W    = $clog2(NMAX);
  localparam int RA_W    = $clog2(2*NMAX+1);
  // One counter serves DRAIN (M cycles), FOLD (M+1) and REDUCE (B+4).
  localparam int CNT_MAX = max_int(MUL_LAT, BRED_LAT + 3);
  localparam int CNT_W   = max_int($clog2(CNT_MAX + 1), 2);

  state_t            state, state_next;
  logic [NW_W-1:0]   n, n_next;
  logic [AD_W-1:0]   k, k_next;
  logic              h, h_next;
  logic [CNT_W-1:0]  cnt, cnt_next;

  logic              mac_issue, fold_issue, red_issue;
  logic              mul_vld, mul_tok, mul_wb;
  logic              bred_vld;
  logic [1:0]        bred_idx;
  logic [3:0]        wen;

  assign mac_issue  = (state == S_MAC);
  assign fold_issue = (state == S_FOLD) && (cnt == '0);
  assign red_issue  = (state == S_REDUCE) && (cnt < CNT_W'(4));

  // MAC and fold products share one writeback delay line.
  red_alu_wb_pipe #(.DEPTH(MUL_LAT), .W(1)) u_mul_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mac_issue | fold_issue),
    .in_data   (1'b1),
    .out_valid (mul_vld),
    .out_data  (mul_tok)
  );

  // Barrett results carry the target core index through their delay line.
  red_alu_wb_pipe #(.DEPTH(BRED_LAT), .W(2)) u_bred_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (red_issue),
    .in_data   (cnt[1:0]),
    .out_valid (bred_vld),
    .out_data  (bred_idx)
  );

  assign mul_wb = mul_vld & mul_tok;

  // State and job registers; reset aborts any job immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      n     <= '0;
      k     <= '0;
      h     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      n     <= n_next;
      k     <= k_next;
      h     <= h_next;
      cnt   <= cnt_next;
    end
  end

  // Phase sequencing: word/half-word stepping in MAC, fixed-length waits elsewhere.
  always_comb begin
    state_next = state;
    n_next     = n;
    k_next     = k;
    h_next     = h;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (start && (num_words != '0)) begin
          state_next = S_CLR;
          n_next     = num_words;
          k_next     = '0;
          h_next     = 1'b0;
        end
      end
      S_CLR: begin
        state_next = S_MAC;
        k_next     = '0;
        h_next     = 1'b0;
      end
      S_MAC: begin
        h_next = ~h;
        if (h) begin
          if ((NW_W'(k) + NW_W'(1)) == n) begin
            state_next = S_DRAIN;
            cnt_next   = '0;
          end else begin
            k_next = k + AD_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_W'(MUL_LAT - 1)) begin
          state_next = S_FOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_FOLD: begin
        if (cnt == CNT_W'(MUL_LAT)) begin
          state_next = S_REDUCE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_REDUCE: begin
        if (cnt == CNT_W'(BRED_LAT + 3)) begin
          state_next = S_FLUSH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_FLUSH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ALU controls: phase selects first, then writeback events override the adder path.
  always_comb begin
    busy              = (state != S_IDLE);
    done              = 1'b0;
    data_rd_addr      = '0;
    rom_addr          = '0;
    rst_acc           = 1'b0;
    only_multiply     = 1'b0;
    m0sel             = 1'b0;
    m1sel             = M1_DATA;
    m2sel             = M2_ACC;
    m3sel             = M3_MUL;
    addsub            = 1'b0;
    barrett_input_sel = 2'd0;
    wen               = 4'b0000;
    out_valid         = 1'b0;
    out_idx           = 2'd0;
    case (state)
      S_CLR: rst_acc = 1'b1;
      S_MAC: begin
        only_multiply = 1'b1;
        m1sel         = M1_DATA;
        data_rd_addr  = k;
        m0sel         = h;
        rom_addr      = RA_W'({k, h});
      end
      // Products still in flight: keep the multiplier in multiply mode.
      S_DRAIN: only_multiply = 1'b1;
      S_FOLD: begin
        only_multiply = 1'b1;
        m1sel         = M1_ACCHI;
        m2sel         = M2_ACCLO;
        rom_addr      = RA_W'(FOLD_ADDR);
      end
      S_REDUCE: begin
        if (red_issue) barrett_input_sel = cnt[1:0];
      end
      S_FLUSH: begin
        out_valid = 1'b1;
        out_idx   = 2'd3;
        done      = 1'b1;
      end
      default: ;
    endcase
    if (mul_wb) begin
      wen    = 4'b1111;
      m2sel  = (state == S_FOLD) ? M2_ACCLO : M2_ACC;
      m3sel  = M3_MUL;
      addsub = 1'b1;
    end
    if (bred_vld) begin
      wen[bred_idx] = 1'b1;
      m2sel         = M2_ZERO;
      m3sel         = M3_BRED;
      addsub        = 1'b1;
      // The ALU result register shows the previous core's value during this write.
      if (bred_idx != 2'd0) begin
        out_valid = 1'b1;
        out_idx   = bred_idx - 2'd1;
      end
    end
  end

  assign wen_acc_core1 = wen[0];
  assign wen_acc_core2 = wen[1];
  assign wen_acc_core3 = wen[2];
  assign wen_acc_core4 = wen[3];

endmodule

// File: tb/tb_red_alu_seq.sv
// Scoreboard bench for red_alu_seq: jobs push per-cycle expectations built
// from the published schedule; a negedge monitor pops and compares.
module tb_red_alu_seq;

  localparam int NMAX = 16;
  localparam int M    = 3;
  localparam int B    = 6;
  localparam int FOLD = 2*NMAX;

  localparam int ISS_NONE = 0, ISS_MAC = 1, ISS_RED = 2;
  localparam int WB_NONE = 0, WB_MAC = 1, WB_FOLD = 2, WB_RED = 3;

  typedef struct {
    bit       busy;
    bit       rst_acc;
    bit       done;
    bit       ov;
    int       oidx;
    bit [3:0] wen;
    int       iss;
    int       k;
    int       h;
    int       c;
    int       wb;
    bit       fold_win;
    bit       red_win;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] num_words;
  logic       busy, done, rst_acc, only_multiply, m0sel, m3sel, addsub;
  logic [3:0] data_rd_addr;
  logic [5:0] rom_addr;
  logic [1:0] m1sel, m2sel, barrett_input_sel, out_idx;
  logic       wen_acc_core1, wen_acc_core2, wen_acc_core3, wen_acc_core4, out_valid;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   jobs     = 0;

  red_alu_seq #(.NMAX(NMAX), .MUL_LAT(M), .BRED_LAT(B), .FOLD_ADDR(FOLD)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .num_words         (num_words),
    .busy              (busy),
    .done              (done),
    .data_rd_addr      (data_rd_addr),
    .rom_addr          (rom_addr),
    .rst_acc           (rst_acc),
    .only_multiply     (only_multiply),
    .m0sel             (m0sel),
    .m3sel             (m3sel),
    .addsub            (addsub),
    .m1sel             (m1sel),
    .m2sel             (m2sel),
    .barrett_input_sel (barrett_input_sel),
    .wen_acc_core1     (wen_acc_core1),
    .wen_acc_core2     (wen_acc_core2),
    .wen_acc_core3     (wen_acc_core3),
    .wen_acc_core4     (wen_acc_core4),
    .out_valid         (out_valid),
    .out_idx           (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int expv);
    n_assert++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, expv);
    end
  endtask

  // Expected cycle-by-cycle picture of one job, from the timing table.
  task automatic push_job(input int n);
    exp_t e[];
    int t, f, r;
    t = 2*n + 7 + 2*M + B;
    f = 2*n + 2 + M;
    r = 2*n + 3 + 2*M;
    e = new[t + 1];
    for (int i = 0; i <= t; i++) begin
      e[i] = '{default: 0};
      e[i].busy = (i >= 1);
    end
    e[1].rst_acc = 1'b1;
    for (int i = 0; i < 2*n; i++) begin
      e[2+i].iss = ISS_MAC;
      e[2+i].k   = i / 2;
      e[2+i].h   = i % 2;
      e[2+i+M].wen = 4'hF;
      e[2+i+M].wb  = WB_MAC;
    end
    for (int i = f; i <= f + M; i++) e[i].fold_win = 1'b1;
    e[f+M].wen = 4'hF;
    e[f+M].wb  = WB_FOLD;
    for (int i = r; i <= r + 3 + B; i++) e[i].red_win = 1'b1;
    for (int c = 0; c < 4; c++) begin
      e[r+c].iss   = ISS_RED;
      e[r+c].c     = c;
      e[r+c+B].wen = 4'(1 << c);
      e[r+c+B].wb  = WB_RED;
      if (c > 0) begin
        e[r+c+B].ov   = 1'b1;
        e[r+c+B].oidx = c - 1;
      end
    end
    e[t].done = 1'b1;
    e[t].ov   = 1'b1;
    e[t].oidx = 3;
    for (int i = 0; i <= t; i++) sb.push_back(e[i]);
  endtask

  // Monitor: every cycle is a transaction; an empty scoreboard means idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{default: 0};
      chk("busy", busy, e.busy);
      chk("rst_acc", rst_acc, e.rst_acc);
      chk("done", done, e.done);
      chk("out_valid", out_valid, e.ov);
      chk("wen", {wen_acc_core4, wen_acc_core3, wen_acc_core2, wen_acc_core1}, e.wen);
      if (e.ov) chk("out_idx", out_idx, e.oidx);
      if (!e.busy)
        chk("idle_ctl", {data_rd_addr, rom_addr, only_multiply, m0sel, m1sel, m2sel,
                         m3sel, addsub, barrett_input_sel, out_idx}, 0);
      if (e.iss == ISS_MAC) begin
        chk("mac_data_addr", data_rd_addr, e.k);
        chk("mac_rom_addr", rom_addr, 2*e.k + e.h);
        chk("mac_m0sel", m0sel, e.h);
        chk("mac_m1sel", m1sel, 0);
        chk("mac_only_mul", only_multiply, 1);
      end
      if (e.fold_win) begin
        chk("fold_m1sel", m1sel, 1);
        chk("fold_m2sel", m2sel, 1);
        chk("fold_rom_addr", rom_addr, FOLD);
        chk("fold_only_mul", only_multiply, 1);
      end
      if (e.red_win) chk("red_only_mul", only_multiply, 0);
      if (e.iss == ISS_RED) chk("red_bsel", barrett_input_sel, e.c);
      case (e.wb)
        WB_MAC:  begin chk("wb_mac_m2", m2sel, 0); chk("wb_mac_m3", m3sel, 0); chk("wb_mac_as", addsub, 1); end
        WB_FOLD: begin chk("wb_fold_m3", m3sel, 0); chk("wb_fold_as", addsub, 1); end
        WB_RED:  begin chk("wb_red_m2", m2sel, 2); chk("wb_red_m3", m3sel, 1); chk("wb_red_as", addsub, 1); end
        default: ;
      endcase
    end
  end

  // One job: optional stray start at mid_cyc, optional start in the done cycle,
  // optional reset at cycle rst_at (0 = none).
  task automatic run_job(input int n, input int mid_cyc, input bit done_start, input int rst_at);
    int t;
    t = 2*n + 7 + 2*M + B;
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = 5'(n);
    push_job(n);
    jobs++;
    $display("job %0d: N=%0d start at cycle %0d stray=%0d done_start=%0d reset_at=%0d",
             jobs, n, cyc, mid_cyc, done_start, rst_at);
    for (int c = 1; c <= t; c++) begin
      @(posedge clk); #1;
      start     = (c == mid_cyc) || (c == t && done_start);
      num_words = start ? 5'($urandom_range(1, NMAX)) : 5'd0;
      if (c == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    start     = 1'b0;
    num_words = 5'd0;
  endtask

  task automatic zero_start();
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = 5'd0;
    $display("zero-length start at cycle %0d (ignored)", cyc);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n, t, mid;
    rst_n     = 1'b1;
    start     = 1'b0;
    num_words = 5'd0;
    #2 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n  = 1'b1;
    repeat (2) @(posedge clk);

    run_job(1, 0, 1'b0, 0);
    run_job(16, 0, 1'b0, 0);
    zero_start();
    run_job(5, 3, 1'b1, 0);
    run_job(6, 0, 1'b0, 2*6 + 3 + 2*M + 2);
    repeat (2) @(posedge clk);
    run_job(4, 0, 1'b0, 0);

    for (int j = 0; j < 12; j++) begin
      n   = $urandom_range(1, NMAX);
      t   = 2*n + 7 + 2*M + B;
      mid = ($urandom_range(0, 1) == 1) ? $urandom_range(1, t - 1) : 0;
      if ($urandom_range(0, 3) == 0) zero_start();
      if ($urandom_range(0, 4) == 0)
        run_job(n, 0, 1'b0, $urandom_range(1, t));
      else
        run_job(n, mid, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected cycles left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
